// File: rtl/render_wb_ctrl.sv
// render_wb_ctrl
// Write-buffer controller between the Mandelbrot render pipeline and the SRAM
// line DMA. Counts x/y over a raster-order iter8 pixel stream, writes each
// pixel into the current ping-pong bank, publishes a completed bank as full
// together with its line number, and recycles banks as the DMA takes and
// finishes them. It pulses frame_done once every line has been committed.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   start                1-cycle pulse, begin a frame at line 0 (ignored while busy)
//   px_valid/px_ready    pixel stream handshake, px_data = iter8 value
//   wb_we/bank/addr/data write-buffer BRAM write port (1 cycle after accept)
//   wb_full0/1, wb_y0/1  per-bank "complete line awaiting commit" flag + line number
//   commit_take/done     DMA start/finish of commit_bank
//   busy                 frame in progress
//   frame_done           1-cycle pulse when the last line has been committed
//   proto_err            sticky, take on a non-FULL bank or done on a non-BUSY bank
//
// state | meaning
// IDLE  | no frame, px_ready low
// RUN   | streaming pixels into fill_bank
// DRAIN | last line written, waiting for the DMA to empty both banks
//
// bank  | meaning
// EMPTY | free
// FILL  | being written by the pixel stream
// FULL  | complete line, waiting for commit_take
// BUSY  | DMA is committing it
module render_wb_ctrl #(
    parameter int FB_W = 960,
    parameter int FB_H = 544
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       px_valid,
    output logic       px_ready,
    input  logic [7:0] px_data,
    output logic       wb_we,
    output logic       wb_bank,
    output logic [9:0] wb_addr,
    output logic [7:0] wb_data,
    output logic       wb_full0,
    output logic       wb_full1,
    output logic [9:0] wb_y0,
    output logic [9:0] wb_y1,
    input  logic       commit_take,
    input  logic       commit_done,
    input  logic       commit_bank,
    output logic       busy,
    output logic       frame_done,
    output logic       proto_err
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} top_t;
    typedef enum logic [1:0] {B_EMPTY, B_FILL, B_FULL, B_BUSY} bank_t;

    localparam logic [9:0] X_LAST = 10'(FB_W - 1);
    localparam logic [9:0] Y_LAST = 10'(FB_H - 1);

    top_t       state;
    bank_t      bank_st [2];
    logic [9:0] x;
    logic [9:0] y;
    logic       fill_bank;

    logic       other_bank;
    logic       accept;
    logic       take_ok;
    logic       done_ok;
    logic       other_free;

    assign other_bank = ~fill_bank;
    assign px_ready   = (state == S_RUN) && (bank_st[fill_bank] == B_FILL);
    assign accept     = px_valid && px_ready;
    assign take_ok    = commit_take && (bank_st[commit_bank] == B_FULL);
    assign done_ok    = commit_done && (bank_st[commit_bank] == B_BUSY);
    // A done on the other bank in the same cycle as a line end frees it in
    // time to start filling immediately, so the stream never stalls.
    assign other_free = (bank_st[other_bank] == B_EMPTY) ||
                        (done_ok && (commit_bank == other_bank));
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            bank_st[0] <= B_EMPTY;
            bank_st[1] <= B_EMPTY;
            x          <= '0;
            y          <= '0;
            fill_bank  <= 1'b0;
            wb_we      <= 1'b0;
            wb_bank    <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            wb_full0   <= 1'b0;
            wb_full1   <= 1'b0;
            wb_y0      <= '0;
            wb_y1      <= '0;
            frame_done <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            // Write port: one cycle behind acceptance, so the final byte of a
            // line lands in the BRAM on the same edge its FULL flag rises.
            wb_we <= accept;
            if (accept) begin
                wb_bank <= fill_bank;
                wb_addr <= x;
                wb_data <= px_data;
            end

            frame_done <= 1'b0;

            if ((commit_take && !take_ok) || (commit_done && !done_ok)) begin
                proto_err <= 1'b1;
            end

            // Commit updates come first; the fill logic below may override a
            // freshly freed bank with FILL in the same cycle.
            if (take_ok) begin
                bank_st[commit_bank] <= B_BUSY;
                if (commit_bank) begin
                    wb_full1 <= 1'b0;
                end else begin
                    wb_full0 <= 1'b0;
                end
            end
            if (done_ok) begin
                bank_st[commit_bank] <= B_EMPTY;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        x          <= '0;
                        y          <= '0;
                        fill_bank  <= 1'b0;
                        bank_st[0] <= B_FILL;
                        state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (x == X_LAST) begin
                            x                  <= '0;
                            y                  <= y + 10'd1;
                            bank_st[fill_bank] <= B_FULL;
                            fill_bank          <= other_bank;
                            if (fill_bank) begin
                                wb_full1 <= 1'b1;
                                wb_y1    <= y;
                            end else begin
                                wb_full0 <= 1'b1;
                                wb_y0    <= y;
                            end
                            if (y == Y_LAST) begin
                                state <= S_DRAIN;
                            end else if (other_free) begin
                                bank_st[other_bank] <= B_FILL;
                            end
                        end else begin
                            x <= x + 10'd1;
                        end
                    end else if (bank_st[fill_bank] == B_EMPTY) begin
                        // Stalled on a bank that has just come back from the DMA.
                        bank_st[fill_bank] <= B_FILL;
                    end
                end
                S_DRAIN: begin
                    if ((bank_st[0] == B_EMPTY) && (bank_st[1] == B_EMPTY)) begin
                        frame_done <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_render_wb_ctrl.sv
// Bench for render_wb_ctrl with a 960-pixel line and a 4-line frame.
// Expected writes come from a frame-level pixel counter: the p-th accepted
// pixel of a frame belongs to line p/W, bank (p/W)%2 and address p%W.
module tb_render_wb_ctrl;

    localparam int W = 960;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       px_valid;
    logic       px_ready;
    logic [7:0] px_data;
    logic       wb_we;
    logic       wb_bank;
    logic [9:0] wb_addr;
    logic [7:0] wb_data;
    logic       wb_full0;
    logic       wb_full1;
    logic [9:0] wb_y0;
    logic [9:0] wb_y1;
    logic       commit_take;
    logic       commit_done;
    logic       commit_bank;
    logic       busy;
    logic       frame_done;
    logic       proto_err;

    render_wb_ctrl #(.FB_W(W), .FB_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .px_valid(px_valid), .px_ready(px_ready), .px_data(px_data),
        .wb_we(wb_we), .wb_bank(wb_bank), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_full0(wb_full0), .wb_full1(wb_full1), .wb_y0(wb_y0), .wb_y1(wb_y1),
        .commit_take(commit_take), .commit_done(commit_done), .commit_bank(commit_bank),
        .busy(busy), .frame_done(frame_done), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         pix = 0;
    logic       exp_we = 1'b0;
    logic       exp_bank = 1'b0;
    logic [9:0] exp_addr = '0;
    logic [7:0] exp_data = '0;
    logic [45:0] outs;

    assign outs = {px_ready, wb_we, wb_bank, wb_addr, wb_data, wb_full0, wb_full1,
                   wb_y0, wb_y1, busy, frame_done, proto_err};

    function automatic string got_wr();
        return $sformatf("we=%b bank=%b addr=%0d data=%02h", wb_we, wb_bank, wb_addr, wb_data);
    endfunction

    function automatic string want_wr();
        return $sformatf("we=%b bank=%b addr=%0d data=%02h", exp_we, exp_bank, exp_addr, exp_data);
    endfunction

    // Advance one clock (negedge to negedge), recording what the accepted
    // pixel, if any, should look like on the write port.
    task automatic step();
        exp_we = px_valid && px_ready;
        if (exp_we) begin
            exp_addr = 10'(pix % W);
            exp_bank = 1'((pix / W) % 2);
            exp_data = px_data;
            pix++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; px_valid = 1'b0; px_data = '0;
        commit_take = 1'b0; commit_done = 1'b0; commit_bank = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_we = 1'b0;
        pix = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; px_valid = 1'b0; px_data = '0;
        commit_take = 1'b0; commit_done = 1'b0; commit_bank = 1'b0;
        @(negedge clk);
        total++;
        if (outs !== 46'd0) begin
            bad++; $display("FAIL reset_outs: got %h want 0", outs);
        end
        rst_n = 1'b1;
        step();
        step();
        total++;
        if (outs !== 46'd0) begin
            bad++; $display("FAIL idle_outs: got %h want 0", outs);
        end
    endtask

    task automatic test_first_line();
        start = 1'b1; pix = 0;
        step();
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || px_ready !== 1'b1) begin
            bad++; $display("FAIL start_ready: got busy=%b ready=%b want 1 1", busy, px_ready);
        end
        px_valid = 1'b1;
        for (int i = 0; i < W; i++) begin
            px_data = 8'(i);
            step();
            total++;
            if (wb_we !== 1'b1 || wb_bank !== 1'b0 || wb_addr !== 10'(i) || wb_data !== 8'(i)) begin
                bad++; $display("FAIL line0_wr: got %s want we=1 bank=0 addr=%0d data=%02h", got_wr(), i, i % 256);
            end
        end
        total++;
        if (wb_full0 !== 1'b1 || wb_y0 !== 10'd0 || wb_full1 !== 1'b0) begin
            bad++; $display("FAIL line0_full: got full0=%b y0=%0d full1=%b want 1 0 0", wb_full0, wb_y0, wb_full1);
        end
        total++;
        if (px_ready !== 1'b1) begin
            bad++; $display("FAIL line0_ready: got %b want 1", px_ready);
        end
        px_valid = 1'b0;
    endtask

    task automatic test_no_commit();
        for (int c = 0; c < 6 * W && pix < 2 * W; c++) begin
            px_valid = ($urandom_range(0, 3) != 0);
            px_data  = 8'($urandom);
            step();
            total++;
            if (wb_we !== exp_we || (exp_we && {wb_bank, wb_addr, wb_data} !== {exp_bank, exp_addr, exp_data})) begin
                bad++; $display("FAIL line1_wr: got %s want %s", got_wr(), want_wr());
            end
        end
        total++;
        if (pix != 2 * W) begin
            bad++; $display("FAIL line1_timeout: got %0d pixels want %0d", pix, 2 * W);
        end
        total++;
        if (px_ready !== 1'b0 || wb_full1 !== 1'b1 || wb_y1 !== 10'd1 || wb_full0 !== 1'b1) begin
            bad++; $display("FAIL both_full: got ready=%b full1=%b y1=%0d full0=%b want 0 1 1 1",
                            px_ready, wb_full1, wb_y1, wb_full0);
        end
        px_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            total++;
            if (wb_we !== 1'b0) begin
                bad++; $display("FAIL stall_we: got %b want 0", wb_we);
            end
        end
        commit_take = 1'b1; commit_bank = 1'b0;
        step();
        commit_take = 1'b0;
        total++;
        if (wb_full0 !== 1'b0 || px_ready !== 1'b0) begin
            bad++; $display("FAIL take0: got full0=%b ready=%b want 0 0", wb_full0, px_ready);
        end
        commit_done = 1'b1; commit_bank = 1'b0;
        step();
        commit_done = 1'b0;
        total++;
        if (px_ready !== 1'b0) begin
            bad++; $display("FAIL done0_ready_early: got %b want 0", px_ready);
        end
        step();
        total++;
        if (px_ready !== 1'b1) begin
            bad++; $display("FAIL done0_ready: got %b want 1", px_ready);
        end
        for (int c = 0; c < 6 * W && pix < 3 * W; c++) begin
            px_valid = ($urandom_range(0, 3) != 0);
            px_data  = 8'($urandom);
            step();
            total++;
            if (wb_we !== exp_we || (exp_we && {wb_bank, wb_addr, wb_data} !== {exp_bank, exp_addr, exp_data})) begin
                bad++; $display("FAIL line2_wr: got %s want %s", got_wr(), want_wr());
            end
        end
        total++;
        if (wb_full0 !== 1'b1 || wb_y0 !== 10'd2 || proto_err !== 1'b0) begin
            bad++; $display("FAIL line2_full: got full0=%b y0=%0d perr=%b want 1 2 0", wb_full0, wb_y0, proto_err);
        end
        do_reset();
    endtask

    task automatic test_full_frame();
        int         ph [2];
        int         cnt [2];
        logic [9:0] yq [$];
        int         nfd = 0;
        int         post = 0;
        logic       pf0 = 1'b0;
        logic       pf1 = 1'b0;
        logic       issued;
        ph[0] = 0; ph[1] = 0; cnt[0] = 0; cnt[1] = 0;
        start = 1'b1; pix = 0;
        step();
        start = 1'b0;
        for (int c = 0; c < 30000 && post < 30; c++) begin
            px_valid = ($urandom_range(0, 3) != 0);
            px_data  = 8'($urandom);
            commit_take = 1'b0; commit_done = 1'b0; issued = 1'b0;
            for (int b = 0; b < 2; b++) begin
                if (!issued && ph[b] != 0 && cnt[b] == 0) begin
                    commit_bank = 1'(b);
                    if (ph[b] == 1) begin
                        commit_take = 1'b1; ph[b] = 2; cnt[b] = $urandom_range(1, 8);
                    end else begin
                        commit_done = 1'b1; ph[b] = 0;
                    end
                    issued = 1'b1;
                end
            end
            for (int b = 0; b < 2; b++) if (cnt[b] > 0) cnt[b]--;
            step();
            total++;
            if (wb_we !== exp_we || (exp_we && {wb_bank, wb_addr, wb_data} !== {exp_bank, exp_addr, exp_data})) begin
                bad++; $display("FAIL frame_wr: got %s want %s", got_wr(), want_wr());
            end
            if (wb_full0 && !pf0) begin yq.push_back(wb_y0); ph[0] = 1; cnt[0] = 20; end
            if (wb_full1 && !pf1) begin yq.push_back(wb_y1); ph[1] = 1; cnt[1] = 20; end
            pf0 = wb_full0; pf1 = wb_full1;
            if (frame_done) nfd++;
            if (nfd > 0) post++;
        end
        commit_take = 1'b0; commit_done = 1'b0;
        total++;
        if (nfd != 1) begin
            bad++; $display("FAIL frame_done_count: got %0d want 1", nfd);
        end
        total++;
        if (yq.size() != H) begin
            bad++; $display("FAIL wb_y_count: got %0d want %0d", yq.size(), H);
        end
        for (int i = 0; i < yq.size() && i < H; i++) begin
            total++;
            if (yq[i] !== 10'(i)) begin
                bad++; $display("FAIL wb_y_seq[%0d]: got %0d want %0d", i, yq[i], i);
            end
        end
        total++;
        if (busy !== 1'b0 || px_ready !== 1'b0 || proto_err !== 1'b0 || pix != W * H) begin
            bad++; $display("FAIL frame_end: got busy=%b ready=%b perr=%b pix=%0d want 0 0 0 %0d",
                            busy, px_ready, proto_err, pix, W * H);
        end
    endtask

    task automatic test_same_cycle_done();
        start = 1'b1; pix = 0;
        step();
        start = 1'b0;
        px_valid = 1'b1;
        for (int c = 0; c < 4 * W && pix < 3 * W + 5; c++) begin
            px_data     = 8'($urandom);
            commit_take = (pix == W + 10) || (pix == 2 * W + 10);
            commit_done = (pix == W + 20) || (pix == 3 * W - 1);
            commit_bank = (pix >= 2 * W);
            total++;
            if (px_ready !== 1'b1) begin
                bad++; $display("FAIL same_cyc_ready: got %b want 1 at pixel %0d", px_ready, pix);
            end
            step();
            commit_take = 1'b0; commit_done = 1'b0;
            total++;
            if (wb_we !== exp_we || (exp_we && {wb_bank, wb_addr, wb_data} !== {exp_bank, exp_addr, exp_data})) begin
                bad++; $display("FAIL same_cyc_wr: got %s want %s", got_wr(), want_wr());
            end
        end
        total++;
        if (pix != 3 * W + 5) begin
            bad++; $display("FAIL same_cyc_timeout: got %0d pixels want %0d", pix, 3 * W + 5);
        end
        total++;
        if (wb_full0 !== 1'b1 || wb_y0 !== 10'd2 || wb_full1 !== 1'b0 || proto_err !== 1'b0) begin
            bad++; $display("FAIL same_cyc_flags: got full0=%b y0=%0d full1=%b perr=%b want 1 2 0 0",
                            wb_full0, wb_y0, wb_full1, proto_err);
        end
    endtask

    task automatic test_proto_err();
        commit_done = 1'b1; commit_bank = 1'b1;
        px_data = 8'($urandom);
        step();
        commit_done = 1'b0;
        total++;
        if (proto_err !== 1'b1 || px_ready !== 1'b1) begin
            bad++; $display("FAIL perr_set: got perr=%b ready=%b want 1 1", proto_err, px_ready);
        end
        start = 1'b1;
        px_data = 8'($urandom);
        step();
        start = 1'b0;
        total++;
        if (wb_we !== exp_we || (exp_we && {wb_bank, wb_addr, wb_data} !== {exp_bank, exp_addr, exp_data})) begin
            bad++; $display("FAIL start_busy_wr: got %s want %s", got_wr(), want_wr());
        end
        for (int c = 0; c < 6 * W && pix < 4 * W; c++) begin
            px_valid = ($urandom_range(0, 3) != 0);
            px_data  = 8'($urandom);
            step();
            total++;
            if (wb_we !== exp_we || (exp_we && {wb_bank, wb_addr, wb_data} !== {exp_bank, exp_addr, exp_data})) begin
                bad++; $display("FAIL perr_fill_wr: got %s want %s", got_wr(), want_wr());
            end
        end
        total++;
        if (px_ready !== 1'b0 || wb_full1 !== 1'b1 || wb_y1 !== 10'd3 || proto_err !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL drain_entry: got ready=%b full1=%b y1=%0d perr=%b busy=%b want 0 1 3 1 1",
                            px_ready, wb_full1, wb_y1, proto_err, busy);
        end
        px_valid = 1'b1;
        commit_bank = 1'b0; commit_take = 1'b1; step(); commit_take = 1'b0;
        commit_done = 1'b1; step(); commit_done = 1'b0;
        commit_bank = 1'b1; commit_take = 1'b1; step(); commit_take = 1'b0;
        commit_done = 1'b1; step(); commit_done = 1'b0;
        total++;
        if (frame_done !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL drain_wait: got fd=%b busy=%b want 0 1", frame_done, busy);
        end
        step();
        total++;
        if (frame_done !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL drain_done: got fd=%b busy=%b want 1 0", frame_done, busy);
        end
        step();
        total++;
        if (frame_done !== 1'b0 || proto_err !== 1'b1) begin
            bad++; $display("FAIL fd_pulse: got fd=%b perr=%b want 0 1", frame_done, proto_err);
        end
        px_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        start = 1'b1; pix = 0;
        step();
        start = 1'b0;
        px_valid = 1'b1;
        for (int c = 0; c < 2 * W && pix < 500; c++) begin
            px_data = 8'($urandom);
            step();
        end
        total++;
        if (wb_we !== 1'b1 || wb_addr !== 10'd499) begin
            bad++; $display("FAIL pre_reset_wr: got %s want we=1 addr=499", got_wr());
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (outs !== 46'd0) begin
            bad++; $display("FAIL mid_reset_outs: got %h want 0", outs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        px_valid = 1'b0;
        step();
        start = 1'b1; pix = 0;
        step();
        start = 1'b0;
        px_valid = 1'b1;
        px_data = 8'h5a;
        step();
        total++;
        if (wb_we !== 1'b1 || wb_bank !== 1'b0 || wb_addr !== 10'd0 || wb_data !== 8'h5a) begin
            bad++; $display("FAIL restart_wr: got %s want we=1 bank=0 addr=0 data=5a", got_wr());
        end
        total++;
        if (wb_full0 !== 1'b0 || wb_full1 !== 1'b0 || proto_err !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL restart_flags: got full0=%b full1=%b perr=%b busy=%b want 0 0 0 1",
                            wb_full0, wb_full1, proto_err, busy);
        end
        px_valid = 1'b0;
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: got no end of run want summary before 3ms");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_line();
        test_no_commit();
        test_full_frame();
        test_same_cycle_done();
        test_proto_err();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
